// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the width helper for the saturating shift counter.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_ROR   = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    // Counter must hold every value from 0 up to and including width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register; master drives the
// operation, slave is the register itself.
interface univ_shift_reg_if
    import usr_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int OUT_WIDTH = 8
);
    localparam int CW = cnt_width(WIDTH);

    logic                 en;
    logic [2:0]           mode;
    logic [WIDTH-1:0]     data_in;
    logic                 ser_in;
    logic [OUT_WIDTH-1:0] data_out;
    logic                 ser_out;
    logic [CW-1:0]        shift_cnt;
    logic                 done;

    modport master (
        output en, mode, data_in, ser_in,
        input  data_out, ser_out, shift_cnt, done
    );

    modport slave (
        input  en, mode, data_in, ser_in,
        output data_out, ser_out, shift_cnt, done
    );

endinterface

// File: rtl/usr_shift_ctr.sv
// Saturating count of shift operations since the last restart, with a sticky
// done flag raised when the count first reaches WIDTH.
module usr_shift_ctr
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       is_shift,
    input  logic                       is_restart,
    output logic [cnt_width(WIDTH)-1:0] cnt,
    output logic                       done
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (en) begin
            if (is_restart) begin
                cnt  <= '0;
                done <= 1'b0;
            end else if (is_shift && cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
                if (cnt == CNT_LAST) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register: load, shifts, rotates and clear with serial in/out,
// zero-extended parallel output and a shift counter for serial conversion.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter int               OUT_WIDTH = 8,
    parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    univ_shift_reg_if.slave        bus
);
    generate
        if (OUT_WIDTH < WIDTH) begin : g_bad_width
            $error("univ_shift_reg: OUT_WIDTH must be >= WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] reg_d;
    logic             ser_q;
    logic             ser_d;
    logic             is_shift;
    logic             is_restart;

    // Concatenations whose slices form each shift result; this form also
    // covers WIDTH=1 without special-casing.
    logic [WIDTH:0]     cat_shl;
    logic [WIDTH:0]     cat_shr;
    logic [WIDTH:0]     cat_asr;
    logic [2*WIDTH-1:0] cat_rot;

    assign cat_shl = {reg_q, bus.ser_in};
    assign cat_shr = {bus.ser_in, reg_q};
    assign cat_asr = {reg_q[WIDTH-1], reg_q};
    assign cat_rot = {reg_q, reg_q};

    always_comb begin
        reg_d      = reg_q;
        ser_d      = ser_q;
        is_shift   = 1'b0;
        is_restart = 1'b0;
        case (bus.mode)
            MODE_LOAD: begin
                reg_d      = bus.data_in;
                is_restart = 1'b1;
            end
            MODE_SHL: begin
                reg_d    = cat_shl[WIDTH-1:0];
                ser_d    = reg_q[WIDTH-1];
                is_shift = 1'b1;
            end
            MODE_SHR: begin
                reg_d    = cat_shr[WIDTH:1];
                ser_d    = reg_q[0];
                is_shift = 1'b1;
            end
            MODE_ROL: begin
                reg_d    = cat_rot[2*WIDTH-2:WIDTH-1];
                ser_d    = reg_q[WIDTH-1];
                is_shift = 1'b1;
            end
            MODE_ROR: begin
                reg_d    = cat_rot[WIDTH:1];
                ser_d    = reg_q[0];
                is_shift = 1'b1;
            end
            MODE_ASR: begin
                reg_d    = cat_asr[WIDTH:1];
                ser_d    = reg_q[0];
                is_shift = 1'b1;
            end
            MODE_CLEAR: begin
                reg_d      = '0;
                ser_d      = 1'b0;
                is_restart = 1'b1;
            end
            default: begin
                reg_d = reg_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_q <= RST_VAL;
            ser_q <= 1'b0;
        end else if (bus.en) begin
            reg_q <= reg_d;
            ser_q <= ser_d;
        end
    end

    usr_shift_ctr #(
        .WIDTH(WIDTH)
    ) u_ctr (
        .clk        (clk),
        .rst        (rst),
        .en         (bus.en),
        .is_shift   (is_shift),
        .is_restart (is_restart),
        .cnt        (bus.shift_cnt),
        .done       (bus.done)
    );

    assign bus.data_out = OUT_WIDTH'(reg_q);
    assign bus.ser_out  = ser_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed plan plus random operations
// compared against an arithmetic reference model.
module tb_univ_shift_reg;
    import usr_pkg::*;

    localparam int               WIDTH     = 4;
    localparam int               OUT_WIDTH = 8;
    localparam logic [WIDTH-1:0] RST_VAL   = 4'h0;
    localparam int               MOD       = 1 << WIDTH;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    univ_shift_reg_if #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

    univ_shift_reg #(
        .WIDTH     (WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .RST_VAL   (RST_VAL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference state, kept as plain integers.
    int m_val;
    int m_ser;
    int m_cnt;
    int m_done;

    int exp_q[5]    = '{5, 11, 7, 15, 15};
    int exp_so[5]   = '{1, 0, 1, 0, 1};
    int exp_cnt[5]  = '{1, 2, 3, 4, 4};
    int exp_done[5] = '{0, 0, 0, 1, 1};

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic model_step(input int r, input int e, input int m,
                              input int d, input int s);
        int top;
        int bot;
        top = m_val / (MOD / 2);
        bot = m_val % 2;
        if (r != 0) begin
            m_val = int'(RST_VAL); m_ser = 0; m_cnt = 0; m_done = 0;
        end else if (e != 0) begin
            case (m)
                1: begin m_val = d; m_cnt = 0; m_done = 0; end
                2: begin m_val = (m_val * 2) % MOD + s;            m_ser = top; end
                3: begin m_val = m_val / 2 + s * (MOD / 2);        m_ser = bot; end
                4: begin m_val = (m_val * 2) % MOD + top;          m_ser = top; end
                5: begin m_val = m_val / 2 + bot * (MOD / 2);      m_ser = bot; end
                6: begin m_val = m_val / 2 + top * (MOD / 2);      m_ser = bot; end
                7: begin m_val = 0; m_ser = 0; m_cnt = 0; m_done = 0; end
                default: ;
            endcase
            if (m >= 2 && m <= 6) begin
                if (m_cnt < WIDTH) m_cnt++;
                if (m_cnt == WIDTH) m_done = 1;
            end
        end
    endtask

    task automatic applyStimulus(input int r, input int e, input int m,
                                 input int d, input int s);
        rst         = (r != 0);
        bus.en      = (e != 0);
        bus.mode    = m[2:0];
        bus.data_in = d[WIDTH-1:0];
        bus.ser_in  = (s != 0);
        @(posedge clk);
        model_step(r, e, m, d, s);
        #1;
        checkOutput("data_out",  32'(bus.data_out),  32'(m_val));
        checkOutput("ser_out",   32'(bus.ser_out),   32'(m_ser));
        checkOutput("shift_cnt", 32'(bus.shift_cnt), 32'(m_cnt));
        checkOutput("done",      32'(bus.done),      32'(m_done));
    endtask

    initial begin
        int r;
        int e;
        m_val = 0; m_ser = 0; m_cnt = 0; m_done = 0;

        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("reset_data_out", 32'(bus.data_out), 32'h00);

        applyStimulus(0, 1, 1, 'hA, 0);
        checkOutput("load_a", 32'(bus.data_out), 32'h0A);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 2, 0, 1);
            checkOutput("shl_q",    32'(bus.data_out),  32'(exp_q[i]));
            checkOutput("shl_ser",  32'(bus.ser_out),   32'(exp_so[i]));
            checkOutput("shl_cnt",  32'(bus.shift_cnt), 32'(exp_cnt[i]));
            checkOutput("shl_done", 32'(bus.done),      32'(exp_done[i]));
        end

        applyStimulus(0, 1, 1, 'h9, 0);
        applyStimulus(0, 1, 6, 0, 0);
        checkOutput("asr1_q", 32'(bus.data_out), 32'h0C);
        checkOutput("asr1_ser", 32'(bus.ser_out), 32'h1);
        applyStimulus(0, 1, 6, 0, 1);
        checkOutput("asr2_q", 32'(bus.data_out), 32'h0E);
        checkOutput("asr2_ser", 32'(bus.ser_out), 32'h0);
        applyStimulus(0, 1, 5, 0, 0);
        checkOutput("ror_q", 32'(bus.data_out), 32'h07);
        checkOutput("ror_ser", 32'(bus.ser_out), 32'h0);

        applyStimulus(0, 0, 1, 'h3, 0);
        checkOutput("en0_hold_q", 32'(bus.data_out), 32'h07);
        applyStimulus(1, 1, 2, 0, 1);
        checkOutput("mid_rst_q", 32'(bus.data_out), 32'h00);
        checkOutput("mid_rst_cnt", 32'(bus.shift_cnt), 32'h0);

        applyStimulus(0, 1, 1, 'hD, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 4, 0, 0);
        checkOutput("pre_clear_done", 32'(bus.done), 32'h1);
        applyStimulus(0, 1, 7, 'hF, 1);
        checkOutput("clear_q", 32'(bus.data_out), 32'h00);
        checkOutput("clear_done", 32'(bus.done), 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 'hF, 1);

        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 24) == 0) ? 1 : 0;
            e = ($urandom_range(0, 3) != 0) ? 1 : 0;
            applyStimulus(r, e, int'($urandom_range(0, 7)),
                          int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
